// File: rtl/serial_paralelo_param.sv
// serial_paralelo_param
// Bit-serial to word-parallel deserialiser with sliding comma alignment.
// Bits arrive MSB first on clk_32f. The block hunts for COMMA on every edge.
// It then confirms LOCK_COUNT aligned commas before it declares the link active.
// Once active, it delivers every non-comma word with a one-cycle valid_out pulse.
// Optional feature macro LOCK_LOSS_EN: while active, count commas that appear
// off the word boundary, and drop back to SEARCH after UNLOCK_COUNT of them.
module serial_paralelo_param #(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] COMMA        = WIDTH'(8'hBC),
  parameter int               LOCK_COUNT   = 4,
  parameter int               UNLOCK_COUNT = 4
) (
  input  logic             clk_32f,
  input  logic             reset,
  input  logic             data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             active,
  output logic [1:0]       lock_state
);

  localparam int BIT_W = $clog2(WIDTH);
  localparam int CNT_W = $clog2(LOCK_COUNT + 1);

  typedef enum logic [1:0] {
    S_SEARCH = 2'b00,
    S_ALIGN  = 2'b01,
    S_ACTIVE = 2'b10
  } state_t;

  // Elaboration-time guard against parameter sets the datapath cannot support.
  if (WIDTH < 4 || LOCK_COUNT < 1 || UNLOCK_COUNT < 1) begin : g_bad_params
    $error("serial_paralelo_param: need WIDTH>=4, LOCK_COUNT>=1, UNLOCK_COUNT>=1");
  end

  state_t           r_state,     w_state_nxt;
  logic [WIDTH-1:0] r_sr;
  logic [BIT_W-1:0] r_bit_cnt,   w_bit_cnt_nxt;
  logic [CNT_W-1:0] r_comma_cnt, w_comma_cnt_nxt;
  logic [WIDTH-1:0] r_data_out,  w_data_out_nxt;
  logic             r_valid,     w_valid_nxt;
  logic             r_active;

  logic [WIDTH-1:0] w_nxt;
  logic             w_is_comma;
  logic             w_boundary;

  // The window includes the bit sampled on this edge, so every compare sees the newest bit.
  assign w_nxt      = {r_sr[WIDTH-2:0], data_in};
  assign w_is_comma = (w_nxt == COMMA);
  assign w_boundary = (r_bit_cnt == BIT_W'(WIDTH - 1));

`ifdef LOCK_LOSS_EN
  localparam int MISS_W = $clog2(UNLOCK_COUNT + 1);
  logic [MISS_W-1:0] r_miss_cnt, w_miss_cnt_nxt;
`endif

  // Next-state and next-output logic for the alignment FSM.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latch).
    w_state_nxt     = r_state;
    w_bit_cnt_nxt   = w_boundary ? '0 : r_bit_cnt + 1'b1;
    w_comma_cnt_nxt = r_comma_cnt;
    w_data_out_nxt  = r_data_out;
    w_valid_nxt     = 1'b0;
`ifdef LOCK_LOSS_EN
    w_miss_cnt_nxt  = r_miss_cnt;
`endif
    unique case (r_state)
      S_SEARCH: begin
        w_bit_cnt_nxt = '0;
        if (w_is_comma) begin
          // The first comma already counts toward lock. The next bit is the MSB of a word.
          w_comma_cnt_nxt = CNT_W'(1);
          w_state_nxt     = (LOCK_COUNT == 1) ? S_ACTIVE : S_ALIGN;
        end
      end
      S_ALIGN: begin
        if (w_boundary) begin
          if (w_is_comma) begin
            if (r_comma_cnt >= CNT_W'(LOCK_COUNT - 1)) begin
              w_comma_cnt_nxt = CNT_W'(LOCK_COUNT);
              w_state_nxt     = S_ACTIVE;
            end else begin
              w_comma_cnt_nxt = r_comma_cnt + 1'b1;
            end
          end else begin
            w_comma_cnt_nxt = '0;
            w_state_nxt     = S_SEARCH;
          end
        end
      end
      S_ACTIVE: begin
        if (w_boundary) begin
          if (!w_is_comma) begin
            w_data_out_nxt = w_nxt;
            w_valid_nxt    = 1'b1;
          end
`ifdef LOCK_LOSS_EN
          else begin
            w_miss_cnt_nxt = '0;
          end
`endif
        end
`ifdef LOCK_LOSS_EN
        else if (w_is_comma) begin
          // A comma seen off the boundary means the word phase has slipped.
          if (r_miss_cnt >= MISS_W'(UNLOCK_COUNT - 1)) begin
            w_miss_cnt_nxt  = '0;
            w_comma_cnt_nxt = '0;
            w_bit_cnt_nxt   = '0;
            w_state_nxt     = S_SEARCH;
          end else begin
            w_miss_cnt_nxt = r_miss_cnt + 1'b1;
          end
        end
`endif
      end
      default: begin
        w_comma_cnt_nxt = '0;
        w_bit_cnt_nxt   = '0;
        w_state_nxt     = S_SEARCH;
      end
    endcase
  end

  // State, counter, shift-register and output registers.
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      // NOTE: the shift register is reset too, so a fresh stream cannot match on stale bits.
      r_state     <= S_SEARCH;
      r_sr        <= '0;
      r_bit_cnt   <= '0;
      r_comma_cnt <= '0;
      r_data_out  <= '0;
      r_valid     <= 1'b0;
      r_active    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here make all registers update together from old values.
      r_state     <= w_state_nxt;
      r_sr        <= w_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_comma_cnt <= w_comma_cnt_nxt;
      r_data_out  <= w_data_out_nxt;
      r_valid     <= w_valid_nxt;
      r_active    <= (w_state_nxt == S_ACTIVE);
    end
  end

`ifdef LOCK_LOSS_EN
  // Misaligned-comma counter, present only when loss of lock is enabled.
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      r_miss_cnt <= '0;
    end else begin
      r_miss_cnt <= w_miss_cnt_nxt;
    end
  end
`else
`endif

  assign data_out   = r_data_out;
  assign valid_out  = r_valid;
  assign active     = r_active;
  assign lock_state = r_state;

endmodule

// File: tb/tb_serial_paralelo_param.sv
// tb_serial_paralelo_param
// Directed bench for serial_paralelo_param with WIDTH=8, COMMA=BC, LOCK_COUNT=4, UNLOCK_COUNT=2.
// Inputs change on the falling edge. Outputs are sampled 1 ns after the rising edge.
// The loss-of-lock scenario follows the LOCK_LOSS_EN macro.
module tb_serial_paralelo_param;

  localparam int WIDTH = 8;

  logic             clk_32f = 1'b0;
  logic             reset   = 1'b1;
  logic             data_in = 1'b0;
  logic [WIDTH-1:0] data_out;
  logic             valid_out;
  logic             active;
  logic [1:0]       lock_state;

  int errors = 0;
  int checks = 0;
  int dbl_valid = 0;
  logic prev_valid = 1'b0;

  serial_paralelo_param #(
    .WIDTH       (WIDTH),
    .COMMA       (8'hBC),
    .LOCK_COUNT  (4),
    .UNLOCK_COUNT(2)
  ) dut (
    .clk_32f   (clk_32f),
    .reset     (reset),
    .data_in   (data_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .active    (active),
    .lock_state(lock_state)
  );

  always #5 clk_32f = ~clk_32f;

  // Count any cycle where valid_out is high two samples in a row.
  always @(negedge clk_32f) begin
    if (valid_out && prev_valid) dbl_valid++;
    prev_valid = valid_out;
  end

  // Hard bound on run time.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk_32f);
    data_in = b;
    @(posedge clk_32f);
    #1;
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic do_reset();
    @(negedge clk_32f);
    reset   = 1'b1;
    data_in = 1'b0;
    repeat (3) @(posedge clk_32f);
    @(negedge clk_32f);
    reset = 1'b0;
  endtask

  initial begin
    // 1. Reset, then an idle stream of zeros.
    do_reset();
    for (int i = 0; i < 32; i++) send_bit(1'b0);
    check("t1_data_out",   32'(data_out),   32'h00);
    check("t1_valid_out",  32'(valid_out),  32'h0);
    check("t1_active",     32'(active),     32'h0);
    check("t1_lock_state", 32'(lock_state), 32'h0);

    // 2. Junk bits 101, then four commas, then the payloads FF and 00.
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    send_word(8'hBC);
    check("t2_align_after_bc1", 32'(lock_state), 32'h1);
    send_word(8'hBC);
    send_word(8'hBC);
    check("t2_active_after_bc3", 32'(active), 32'h0);
    send_word(8'hBC);
    check("t2_active_after_bc4", 32'(active),     32'h1);
    check("t2_lock_active",      32'(lock_state), 32'h2);
    check("t2_no_valid_on_bc",   32'(valid_out),  32'h0);
    send_word(8'hFF);
    check("t2_valid_ff", 32'(valid_out), 32'h1);
    check("t2_data_ff",  32'(data_out),  32'hFF);
    send_bit(1'b0);
    check("t2_valid_drop", 32'(valid_out), 32'h0);
    for (int i = 6; i >= 0; i--) send_bit(1'b0);
    check("t2_valid_00", 32'(valid_out), 32'h1);
    check("t2_data_00",  32'(data_out),  32'h00);

    // 3. Partial lock that a non-comma word breaks, then a full relock.
    do_reset();
    send_word(8'hBC);
    send_word(8'hBC);
    check("t3_align_mid", 32'(lock_state), 32'h1);
    send_word(8'hAA);
    check("t3_search_after_aa", 32'(lock_state), 32'h0);
    check("t3_inactive_aa",     32'(active),     32'h0);
    check("t3_no_valid_aa",     32'(valid_out),  32'h0);
    send_word(8'hBC); send_word(8'hBC); send_word(8'hBC);
    check("t3_not_yet", 32'(active), 32'h0);
    send_word(8'hBC);
    check("t3_relock",      32'(active),     32'h1);
    check("t3_relock_lock", 32'(lock_state), 32'h2);

    // 4. Payload, comma, payload: the comma word produces no strobe.
    send_word(8'h5A);
    check("t4_valid_5a", 32'(valid_out), 32'h1);
    check("t4_data_5a",  32'(data_out),  32'h5A);
    send_word(8'hBC);
    check("t4_no_valid_bc", 32'(valid_out), 32'h0);
    check("t4_data_hold",   32'(data_out),  32'h5A);
    send_word(8'h3C);
    check("t4_valid_3c", 32'(valid_out), 32'h1);
    check("t4_data_3c",  32'(data_out),  32'h3C);

    // 5. Reset asserted mid-word clears outputs at once. A relock then needs 4 commas.
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("t5_data_async",   32'(data_out),   32'h00);
    check("t5_valid_async",  32'(valid_out),  32'h0);
    check("t5_active_async", 32'(active),     32'h0);
    check("t5_lock_async",   32'(lock_state), 32'h0);
    data_in = 1'b0;
    repeat (2) @(posedge clk_32f);
    @(negedge clk_32f);
    reset = 1'b0;
    send_word(8'hBC); send_word(8'hBC); send_word(8'hBC);
    check("t5_not_yet", 32'(active), 32'h0);
    send_word(8'hBC);
    check("t5_relock", 32'(active), 32'h1);

    // 6. Phase slip of 3 bits, then commas on the new phase.
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
    send_word(8'hBC);
    send_word(8'hBC);
`ifdef LOCK_LOSS_EN
    check("t6_unlock_active", 32'(active),     32'h0);
    check("t6_unlock_state",  32'(lock_state), 32'h0);
    send_word(8'hBC); send_word(8'hBC); send_word(8'hBC);
    check("t6_not_yet", 32'(active), 32'h0);
    send_word(8'hBC);
    check("t6_relock",       32'(active),     32'h1);
    check("t6_relock_state", 32'(lock_state), 32'h2);
`else
    check("t6_sticky_active", 32'(active),     32'h1);
    check("t6_sticky_state",  32'(lock_state), 32'h2);
    send_word(8'hBC); send_word(8'hBC); send_word(8'hBC); send_word(8'hBC);
    check("t6_still_active", 32'(active), 32'h1);
`endif

    check("valid_never_back_to_back", 32'(dbl_valid), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
